// File: rtl/rv32i_data_path.sv
// Single-cycle RV32I datapath.
// It contains the PC, a 32x32 register file, the immediate decoder, the ALU,
// the writeback mux and the next-PC selection. The control unit, the
// instruction memory and the data memory all sit outside this block.
module rv32i_data_path (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  input  logic        branch,
  input  logic [1:0]  jump,
  input  logic        reg_w,
  input  logic        alu_s,
  input  logic [2:0]  alu_op,
  input  logic [1:0]  dato_s,
  output logic [31:0] alu_res,
  output logic        flag,
  output logic [6:0]  op_code,
  output logic [2:0]  f3,
  output logic        f7,
  output logic [31:0] write_data,
  output logic [15:0] pc
);

  localparam int XLEN = 32;
  localparam int PCW  = 16;

  logic [XLEN-1:0] regFile [32];
  logic [4:0]      rs1Addr, rs2Addr, rdAddr;
  logic [XLEN-1:0] rs1Val, rs2Val, immVal, aluB, wbData;
  logic [PCW-1:0]  pcPlus4, nextPc;

  // Sign-extended immediate, with the format chosen by the opcode.
  function automatic logic [XLEN-1:0] decodeImm(input logic [XLEN-1:0] ins);
    logic [XLEN-1:0] imm;
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111:
        imm = {{20{ins[31]}}, ins[31:20]};
      7'b0100011:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      7'b1100011:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      7'b1101111:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      7'b0110111, 7'b0010111:
        imm = {ins[31:12], 12'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  // The eight ALU operations. All arithmetic wraps modulo 2^32, and slt
  // compares the two operands as signed values.
  function automatic logic [XLEN-1:0] aluCompute(input logic [2:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] aSigned;
    logic signed [XLEN-1:0] bSigned;
    logic [XLEN-1:0]        res;
    aSigned = a;
    bSigned = b;
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = a ^ b;
      3'b101:  res = {{(XLEN-1){1'b0}}, (aSigned < bSigned)};
      3'b110:  res = a << b[4:0];
      default: res = a >> b[4:0];
    endcase
    return res;
  endfunction

  assign op_code = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[30];
  assign rs1Addr = instr[19:15];
  assign rs2Addr = instr[24:20];
  assign rdAddr  = instr[11:7];

  // Asynchronous register reads. x0 is forced to zero on the read side, so
  // its value is correct no matter what the storage holds.
  always_comb begin
    rs1Val = (rs1Addr == 5'd0) ? '0 : regFile[rs1Addr];
    rs2Val = (rs2Addr == 5'd0) ? '0 : regFile[rs2Addr];
  end

  assign immVal     = decodeImm(instr);
  assign aluB       = alu_s ? immVal : rs2Val;
  assign alu_res    = aluCompute(alu_op, rs1Val, aluB);
  assign flag       = (alu_res == '0);
  assign write_data = rs2Val;
  assign pcPlus4    = pc + 16'd4;

  // Writeback source select. The pc+4 sum is truncated to 16 bits and then
  // zero-extended to 32 bits.
  always_comb begin
    case (dato_s)
      2'b00:   wbData = alu_res;
      2'b01:   wbData = read_data;
      2'b10:   wbData = immVal;
      default: wbData = {{(XLEN-PCW){1'b0}}, pcPlus4};
    endcase
  end

  // Next-PC selection. A jump overrides a branch, and the reserved jump
  // code 11 falls through to sequential flow.
  always_comb begin
    nextPc = pcPlus4;
    case (jump)
      2'b10:   nextPc = pc + immVal[PCW-1:0];
      2'b01:   nextPc = alu_res[PCW-1:0] & 16'hFFFE;
      2'b00:   if (branch && flag) nextPc = pc + immVal[PCW-1:0];
      default: nextPc = pcPlus4;
    endcase
  end

  // The PC register advances on every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= nextPc;
  end

  // Register-file write port. A write to rd = 0 is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else if (reg_w && (rdAddr != 5'd0)) begin
      regFile[rdAddr] <= wbData;
    end
  end

endmodule

// File: tb/tb_rv32i_data_path.sv
// Testbench for rv32i_data_path. A driver applies one instruction per clock
// and pushes the expected outputs, taken from an architectural model, into a
// scoreboard queue. A separate monitor pops the queue and compares the
// entries against the DUT.
module tb_rv32i_data_path;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] read_data = '0;
  logic        branch = 1'b0;
  logic [1:0]  jump = 2'b00;
  logic        reg_w = 1'b0;
  logic        alu_s = 1'b0;
  logic [2:0]  alu_op = 3'b000;
  logic [1:0]  dato_s = 2'b00;
  logic [31:0] alu_res;
  logic        flag;
  logic [6:0]  op_code;
  logic [2:0]  f3;
  logic        f7;
  logic [31:0] write_data;
  logic [15:0] pc;

  rv32i_data_path dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .read_data(read_data),
    .branch(branch), .jump(jump), .reg_w(reg_w), .alu_s(alu_s),
    .alu_op(alu_op), .dato_s(dato_s), .alu_res(alu_res), .flag(flag),
    .op_code(op_code), .f3(f3), .f7(f7), .write_data(write_data), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] aluRes;
    logic        flag;
    logic [31:0] wd;
    logic [15:0] pc;
    logic [10:0] fields;
  } exp_t;

  exp_t sbQ[$];
  int nChecks = 0;
  int nPass   = 0;

  // Architectural state of the reference model.
  logic [31:0] mRf [32];
  logic [15:0] mPc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act === req) nPass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Sign-extends the value v, treating it as a two's-complement number of
  // the given bit width.
  function automatic logic [31:0] sext(input longint v, input int bits);
    longint m;
    m = longint'(1) << bits;
    if (v >= m / 2) v = v - m;
    return 32'(v);
  endfunction

  function automatic logic [31:0] refImm(input logic [31:0] i);
    longint v;
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return sext(longint'(i[31:20]), 12);
      7'h23: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        return sext(v, 12);
      end
      7'h63: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        return sext(v, 13);
      end
      7'h6F: begin
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        return sext(v, 21);
      end
      7'h37, 7'h17: return longint'(i[31:12]) * 4096;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return a << (b % 32);
      default: return a >> (b % 32);
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mRf[i] = '0;
    mPc = '0;
  endtask

  // Computes the expected outputs for the inputs currently applied and
  // pushes them to the scoreboard. When doStep is set, the model then
  // commits the clock edge that follows.
  task automatic predict(input string nm, input bit doStep);
    exp_t e;
    logic [31:0] a, b, imm, res, wb;
    int rd, nxt;
    a   = mRf[instr[19:15]];
    b   = mRf[instr[24:20]];
    imm = refImm(instr);
    res = refAlu(alu_op, a, alu_s ? imm : b);
    e.name   = nm;
    e.aluRes = res;
    e.flag   = (res == 0);
    e.wd     = b;
    e.pc     = mPc;
    e.fields = {instr[30], instr[14:12], instr[6:0]};
    sbQ.push_back(e);
    if (doStep) begin
      case (dato_s)
        2'd0: wb = res;
        2'd1: wb = read_data;
        2'd2: wb = imm;
        default: wb = (int'(mPc) + 4) % 65536;
      endcase
      if (jump == 2'b10)                           nxt = int'(mPc) + int'(imm[15:0]);
      else if (jump == 2'b01)                      nxt = int'(res[15:0]) / 2 * 2;
      else if (jump == 2'b00 && branch && res == 0) nxt = int'(mPc) + int'(imm[15:0]);
      else                                         nxt = int'(mPc) + 4;
      rd = int'(instr[11:7]);
      if (reg_w && rd != 0) mRf[rd] = wb;
      mPc = 16'(nxt % 65536);
    end
  endtask

  task automatic issue(input string nm, input logic [31:0] ins, input logic br,
                       input logic [1:0] jp, input logic rw, input logic as,
                       input logic [2:0] op, input logic [1:0] ds,
                       input logic [31:0] rdata);
    @(negedge clk);
    rst_n = 1'b1;
    instr = ins; branch = br; jump = jp; reg_w = rw; alu_s = as;
    alu_op = op; dato_s = ds; read_data = rdata;
    predict(nm, 1'b1);
  endtask

  task automatic resetPulse(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    predict(nm, 1'b0);
  endtask

  function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] encR(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction

  // Puts register x[n] onto alu_res as (x[n] | x0), with no writeback.
  task automatic readback(input string nm, input logic [4:0] n);
    issue(nm, encR(5'd0, n, 5'd0), 1'b0, 2'b00, 1'b0, 1'b0, 3'd3, 2'd0, 32'd0);
  endtask

  // Monitor process.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        chk({e.name, ".alu_res"}, alu_res, e.aluRes);
        chk({e.name, ".flag"}, {31'd0, flag}, {31'd0, e.flag});
        chk({e.name, ".write_data"}, write_data, e.wd);
        chk({e.name, ".pc"}, {16'd0, pc}, {16'd0, e.pc});
        chk({e.name, ".fields"}, {21'd0, f7, f3, op_code}, {21'd0, e.fields});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OPS [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63,
                                     7'h6F, 7'h37, 7'h17, 7'h33};

  initial begin
    logic [31:0] r;
    modelReset();
    resetPulse("reset");
    // JAL x4, 2100
    issue("jal", 32'h0350026F, 1'b0, 2'b10, 1'b1, 1'b0, 3'd0, 2'd3, 32'd0);
    readback("rb_x4", 5'd4);
    // ADDI x2, x0, 21
    issue("addi", 32'h01500113, 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    readback("rb_x2", 5'd2);
    // BEQ taken, then not taken
    issue("x1_5", encI(12'd5, 5'd0, 5'd1, 7'h13), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    issue("x2_5", encI(12'd5, 5'd0, 5'd2, 7'h13), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    issue("beq_t", encB(13'd36, 5'd2, 5'd1), 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 2'd0, 32'd0);
    issue("x2_6", encI(12'd6, 5'd0, 5'd2, 7'h13), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    issue("beq_n", encB(13'd36, 5'd2, 5'd1), 1'b1, 2'b00, 1'b0, 1'b0, 3'd1, 2'd0, 32'd0);
    // JALR wrap-around, then sequential wrap from 0xFFFC
    issue("ld_ffff", encI(12'd0, 5'd0, 5'd1, 7'h03), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd1, 32'h0000FFFF);
    issue("jalr", encI(12'd3, 5'd1, 5'd0, 7'h67), 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);
    issue("ld_fffc", encI(12'd0, 5'd0, 5'd1, 7'h03), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd1, 32'h0000FFFC);
    issue("jalr_fffc", encI(12'd0, 5'd1, 5'd0, 7'h67), 1'b0, 2'b01, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);
    issue("seq_wrap", encI(12'd0, 5'd0, 5'd0, 7'h13), 1'b0, 2'b00, 1'b0, 1'b1, 3'd0, 2'd0, 32'd0);
    readback("pc_after_wrap", 5'd0);
    // Writes to x0 are dropped, and a load writes read_data to rd.
    issue("x0_w", encI(12'd7, 5'd0, 5'd0, 7'h13), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd0, 32'd0);
    readback("rb_x0", 5'd0);
    issue("lw_x5", encI(12'd0, 5'd0, 5'd5, 7'h03), 1'b0, 2'b00, 1'b1, 1'b1, 3'd0, 2'd1, 32'hDEADBEEF);
    readback("rb_x5", 5'd5);
    // Random instruction stream.
    for (int k = 0; k < 250; k++) begin
      r = $urandom();
      issue("rand", {r[31:7], OPS[$urandom_range(0, 8)]}, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom());
    end
    // Reset in the middle of the run: the PC and every register return to 0.
    resetPulse("mid_reset");
    readback("rst_x2", 5'd2);
    readback("rst_x5", 5'd5);
    for (int k = 0; k < 60; k++) begin
      r = $urandom();
      issue("rand2", {r[31:7], OPS[$urandom_range(0, 8)]}, 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom());
    end
    @(negedge clk);
    #5;
    nChecks++;
    if (sbQ.size() == 0) nPass++;
    else $display("FAIL drain: %0d entries left, required 0", sbQ.size());
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
